// File: rtl/shake_serial_tx.sv
// shake_serial_tx: byte stream to SHAKE256 2-bit serial interface with FIFO and done tracking
module shake_serial_tx #(
  parameter int FIFO_DEPTH = 8,
  parameter int START_GAP  = 2,
  parameter int BYTE_GAP   = 1,
  parameter int END_GAP    = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_data,
  input  logic        in_keep,
  input  logic        in_last,
  input  logic        core_done,
  output logic        start,
  output logic        enable,
  output logic [1:0]  serial_in,
  output logic        serial_end_signal,
  output logic        busy,
  output logic        msg_done,
  output logic [10:0] byte_count
);
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic [3:0] {IDLE, START, SWAIT, FETCH, SHIFT, BGAP, EGAP, END, WAIT_DONE} state_t;
  state_t state, state_n;
  logic [9:0] mem [FIFO_DEPTH];
  logic [AW:0] wp, rp;
  logic [9:0] head;
  logic empty, full, push, pop, last_q;
  logic [15:0] cnt;
  logic [7:0] shreg, sh_n;
  assign head = mem[rp[AW-1:0]];
  assign empty = wp == rp;
  assign full = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign in_ready = !full;
  assign push = in_valid && !full;
  assign pop = state == FETCH && !empty;
  always_ff @(posedge clk)
    if (push) mem[wp[AW-1:0]] <= {in_keep, in_last, in_data};
  always_comb begin
    state_n = state;
    sh_n = shreg;
    case (state)
      IDLE:      state_n = empty ? IDLE : START;
      START:     state_n = SWAIT;
      SWAIT:     state_n = cnt == 16'(START_GAP - 1) ? FETCH : SWAIT;
      FETCH:
        if (!empty) begin
          state_n = head[9] ? SHIFT : EGAP;
          sh_n = head[7:0];
        end
      SHIFT: begin
        sh_n = {shreg[5:0], 2'b00};
        if (cnt == 16'd3) state_n = BYTE_GAP > 0 ? BGAP : (last_q ? EGAP : FETCH);
      end
      BGAP:      state_n = cnt == 16'(BYTE_GAP - 1) ? (last_q ? EGAP : FETCH) : BGAP;
      EGAP:      state_n = cnt == 16'(END_GAP - 1) ? END : EGAP;
      END:       state_n = WAIT_DONE;
      WAIT_DONE: state_n = core_done ? IDLE : WAIT_DONE;
      default:   state_n = IDLE;
    endcase
  end
  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      shreg <= '0;
      last_q <= 1'b0;
      wp <= '0;
      rp <= '0;
      byte_count <= '0;
      start <= 1'b0;
      enable <= 1'b0;
      serial_in <= 2'b00;
      serial_end_signal <= 1'b0;
      busy <= 1'b0;
      msg_done <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= state_n != state ? 16'd0 : cnt + 16'd1;
      shreg <= sh_n;
      if (push) wp <= wp + 1'b1;
      if (pop) begin
        rp <= rp + 1'b1;
        last_q <= head[8] | ~head[9];
      end
      if (state == IDLE && !empty) byte_count <= '0;
      else if (state == SHIFT && cnt == 16'd3 && byte_count != 11'h7ff) byte_count <= byte_count + 11'd1;
      start <= state_n == START;
      enable <= state_n == SHIFT;
      serial_in <= state_n == SHIFT ? sh_n[7:6] : 2'b00;
      serial_end_signal <= state_n == END;
      busy <= state_n != IDLE;
      msg_done <= state == WAIT_DONE && core_done;
    end
endmodule

// File: tb/tb_shake_serial_tx.sv
// tb_shake_serial_tx: scoreboard bench; driver queues expected chunks/counts, monitor checks DUT output
module tb_shake_serial_tx;
  logic clk = 0, reset = 1, in_valid = 0, in_keep = 0, in_last = 0, core_done = 0;
  logic [7:0] in_data = 0;
  logic in_ready, start, enable, serial_end_signal, busy, msg_done;
  logic [1:0] serial_in;
  logic [10:0] byte_count;
  shake_serial_tx dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_keep(in_keep), .in_last(in_last), .core_done(core_done), .start(start), .enable(enable),
    .serial_in(serial_in), .serial_end_signal(serial_end_signal), .busy(busy),
    .msg_done(msg_done), .byte_count(byte_count)
  );
  always #5 clk = ~clk;
  int total = 0, bad = 0, cyc = 0;
  int accepted = 0, nb = 0, exp_msgs = 0, starts = 0, dones = 0, en_cnt = 0, pend = 0;
  bit hold_done = 0, done_level = 0, mon_on = 0;
  logic [1:0] exp_chunks[$];
  int exp_counts[$];
  always @(posedge clk) cyc++;
  task automatic chk(input string n, input int a, input int e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d at cycle %0d", n, a, e, cyc);
    end
  endtask
  // Reference model: each accepted data beat yields its four MSB-first bit pairs;
  // a message closes on last=1 or any keep=0 beat, carrying its data-beat count.
  task automatic send(input logic [7:0] d, input logic k, input logic l);
    int t = 0;
    logic ok;
    @(negedge clk);
    in_valid = 1; in_data = d; in_keep = k; in_last = l;
    do begin ok = in_ready; @(posedge clk); #1; t++; end while (!ok && t < 500);
    in_valid = 0;
    if (!ok) chk("send_timeout", 0, 1);
    else begin
      accepted++;
      if (k) begin
        for (int i = 0; i < 4; i++) exp_chunks.push_back(d[7-2*i -: 2]);
        nb++;
      end
      if (l || !k) begin
        exp_counts.push_back(nb);
        nb = 0;
        exp_msgs++;
      end
    end
  endtask
  always @(negedge clk)
    if (!reset && mon_on) begin
      if (enable) begin
        en_cnt++;
        if (exp_chunks.size() == 0) chk("chunk_underrun", 1, 0);
        else chk("chunk", serial_in, exp_chunks.pop_front());
      end else if (serial_in != 2'b00) chk("idle_serial", serial_in, 0);
      if (int'(start) + int'(enable) + int'(serial_end_signal) > 1) chk("exclusive", 0, 1);
      if (serial_end_signal) begin
        if (exp_counts.size() == 0) chk("end_unexpected", 1, 0);
        else chk("byte_count_at_end", byte_count, exp_counts.pop_front());
      end
      if (msg_done) dones++;
      if (start) begin
        chk("start_after_done", starts - dones, 0);
        starts++;
      end
    end
  initial forever begin
    @(negedge clk);
    if (done_level) core_done = 1;
    else begin
      core_done = 0;
      if (serial_end_signal && !reset) pend++;
      if (pend > 0 && !hold_done) begin
        repeat ($urandom_range(1, 4)) @(negedge clk);
        core_done = 1;
        pend--;
        @(negedge clk);
        core_done = 0;
      end
    end
  end
  task automatic wait_cond(input int which, input string n, output int at);
    int t = 0;
    logic hit;
    do begin
      @(negedge clk);
      t++;
      hit = which == 0 ? start : which == 1 ? serial_end_signal : which == 2 ? msg_done : enable;
    end while (!hit && t < 1000);
    at = cyc;
    if (!hit) chk(n, 0, 1);
  endtask
  task automatic drain(input string n);
    int t = 0;
    while (dones < exp_msgs && t < 3000) begin @(negedge clk); t++; end
    chk(n, dones, exp_msgs);
    chk({n, "_chunks_left"}, exp_chunks.size(), 0);
  endtask
  initial begin
    int s, e, en0, st0, acc0, len;
    bit term;
    logic [7:0] dig [8];
    dig = '{8'h44, 8'h69, 8'h67, 8'h69, 8'h74, 8'h61, 8'h6c, 8'h32};
    repeat (3) @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_outs", {start, enable, serial_in, serial_end_signal, busy, msg_done}, 0);
    chk("rst_byte_count", byte_count, 0);
    reset = 0;
    mon_on = 1;
    en0 = en_cnt;
    send(8'h00, 0, 1);
    wait_cond(0, "empty_start", s);
    wait_cond(1, "empty_end", e);
    chk("empty_gap", e - s, 5);
    chk("empty_enables", en_cnt - en0, 0);
    drain("empty_done");
    send(8'h61, 1, 0); send(8'h62, 1, 0); send(8'h63, 1, 1);
    drain("abc_done");
    chk("abc_byte_count", byte_count, 3);
    hold_done = 1;
    send(8'h00, 0, 1);
    wait_cond(1, "bp_end", e);
    acc0 = accepted;
    fork
      for (int i = 0; i < 10; i++) send(8'($urandom), 1, i == 9);
      begin
        repeat (15) @(negedge clk);
        chk("bp_accepted", accepted - acc0, 8);
        chk("bp_in_ready", in_ready, 0);
        chk("bp_busy", busy, 1);
        hold_done = 0;
      end
    join
    drain("bp_done");
    chk("bp_byte_count", byte_count, 10);
    st0 = starts;
    en0 = en_cnt;
    send(8'h35, 1, 0);
    repeat (20) @(negedge clk);
    chk("stall_enables", en_cnt - en0, 4);
    send(8'h61, 1, 1);
    drain("stall_done");
    chk("stall_single_start", starts - st0, 1);
    for (int i = 0; i < 8; i++) send(dig[i], 1, i == 7);
    send(8'h61, 1, 0); send(8'h62, 1, 0); send(8'h63, 1, 1);
    drain("b2b_done");
    chk("b2b_byte_count", byte_count, 3);
    done_level = 1;
    send(8'hc3, 1, 1);
    send(8'h00, 0, 1);
    drain("level_done");
    done_level = 0;
    for (int m = 0; m < 20; m++) begin
      len = $urandom_range(0, 5);
      term = len == 0 || $urandom_range(0, 1) == 1;
      for (int i = 0; i < len; i++) begin
        send(8'($urandom), 1, !term && i == len - 1);
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      if (term) send(8'($urandom), 0, 1'($urandom_range(0, 1)));
    end
    drain("rand_done");
    send(8'haa, 1, 0);
    send(8'hbb, 1, 1);
    wait_cond(3, "rst_mid_enable", s);
    #2 reset = 1;
    #1;
    chk("mid_rst_outs", {start, enable, serial_in, serial_end_signal, busy, msg_done}, 0);
    chk("mid_rst_byte_count", byte_count, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    exp_chunks.delete();
    exp_counts.delete();
    nb = 0;
    exp_msgs = dones;
    starts = dones;
    @(negedge clk);
    reset = 0;
    repeat (4) @(negedge clk);
    chk("post_rst_idle", busy, 0);
    send(8'h5a, 1, 1);
    drain("post_rst_done");
    chk("post_rst_byte_count", byte_count, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
  initial begin
    #600000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end
endmodule
